tdc_sweep_checker: RTL and testbench
====================================

Name: tdc_sweep_checker

Overview:
- Consumer side of the TDC debug hit sweep.
- Takes one encoded TDC bin per debug hit and checks that measured bins rise monotonically across each sweep of NUM_TAPS steps.
- Counts violations, tracks per-cycle min/max and the largest single-step jump, and raises done/pass after CYCLES full sweeps.
- Sits after the TDC encoder, beside the hit generator; its results go to the readout/UART path.

Parameters:
- NUM_TAPS, 240, hit steps per sweep cycle; must equal the `NUM_TAPS define.
- BIN_W, 9, width of encoded bin value.
- CYCLES, 3, sweep cycles expected before done.
- TOL, 2, allowed backward step, in bins, before flagging a monotonicity error.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  checker enable; tie to the debug sweep enable.
- bin_valid  in  1  one-cycle strobe, one per measured hit.
- bin_value  in  BIN_W  encoded bin of the current hit.
- sweep_finished  in  1  level from the hit generator: sweep complete.
- step_idx  out  BIN_W  current step within the cycle, 0..NUM_TAPS-1.
- cycle_idx  out  3  completed cycles.
- err_count  out  ERR_W  monotonicity violations, saturating.
- max_jump  out  BIN_W  largest forward step bin(n)-bin(n-1) seen.
- cyc_min  out  BIN_W  min bin in the current/last cycle.
- cyc_max  out  BIN_W  max bin in the current/last cycle.
- short_sweep  out  1  sweep_finished seen before CYCLES cycles completed.
- done  out  1  checking complete, sticky.
- pass  out  1  valid when done: err_count==0 and !short_sweep.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE.
  - step_idx, cycle_idx, err_count, max_jump, short_sweep, done, pass = 0.
  - cyc_min = all ones; cyc_max = 0; prev_bin register = 0.
- FSM states: IDLE, FIRST, TRACK, CYC_END, DONE.
- IDLE: on enable=1, clear all counters and stats (same values as reset), go to FIRST next cycle.
- FIRST (first sample of a cycle) on bin_valid:
  - prev_bin <= bin_value; cyc_min = cyc_max = bin_value.
  - No monotonicity check; step_idx <= 1; go to TRACK.
- TRACK on bin_valid:
  - Error when bin_value + TOL < prev_bin. Compare at BIN_W+1 bits so there is no wrap. On error, err_count += 1, saturating at all ones.
  - Forward step (bin_value >= prev_bin): if bin_value-prev_bin > max_jump, update max_jump.
  - Update cyc_min/cyc_max and prev_bin.
  - If step_idx == NUM_TAPS-1: go to CYC_END and leave step_idx at NUM_TAPS-1; otherwise step_idx += 1.
- CYC_END: one cycle long.
  - cycle_idx += 1.
  - If the new cycle_idx == CYCLES, go to DONE; otherwise step_idx <= 0 and go to FIRST.
  - bin_valid arriving in CYC_END is dropped and counted as an error.
  - cyc_min/cyc_max hold last-cycle values until the next FIRST sample.
- DONE:
  - done=1 (sticky); pass = (err_count==0) & !short_sweep, registered on entry.
  - bin_valid is ignored.
  - Leaves only on reset, or on enable falling then rising again (through IDLE).
- sweep_finished:
  - Sampled in FIRST, TRACK and CYC_END.
  - If it rises while the next cycle_idx would still be < CYCLES: set short_sweep=1 and go to DONE with pass=0.
  - If bin_valid and sweep_finished arrive in the same cycle, process the bin first, then evaluate sweep_finished against the updated cycle_idx.
- enable=0 in any non-DONE state: abort to IDLE next cycle. Outputs hold their values; done stays 0.
- Latency: stats update 1 clk after the bin_valid edge; done/pass 1 clk after CYC_END of the last cycle.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Ideal sweep: 3 cycles x 240 bins, bin=step*2 -> err_count=0, max_jump=2, cyc_min=0, cyc_max=478, cycle_idx=3, done=1, pass=1.
- Dip within tolerance: sequence 100,101,99 -> no error. Sequence 100,101,98 -> err_count=1, and pass=0 at end.
- sweep_finished asserted after cycle 1 (cycle_idx=1) -> short_sweep=1, done=1, pass=0 on the next clk.
- Simultaneous bin_valid (step 239, cycle 2) and sweep_finished -> CYC_END, cycle_idx=3, short_sweep=0, done=1, pass=1.
- rst driven low mid-TRACK (step 57) asynchronously -> all outputs return to reset values immediately. After release and enable=1, sweep restarts from step 0.
- enable dropped at step 120 and re-raised -> IDLE clears stats; err_count=0, step_idx=0; FIRST accepts the next bin without a check.

Source files
------------

// File: rtl/tdc_sweep_checker.sv
// Consumer side of the TDC debug hit sweep: checks that encoded bins rise monotonically
// across each sweep of NUM_TAPS steps and reports error/jump/range statistics.
module tdc_sweep_checker #(
   parameter int NUM_TAPS = 240,
   parameter int BIN_W    = 9,
   parameter int CYCLES   = 3,
   parameter int TOL      = 2,
   parameter int ERR_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_bin_valid,
   input  logic [BIN_W-1:0] i_bin_value,
   input  logic             i_sweep_finished,
   output logic [BIN_W-1:0] o_step_idx,
   output logic [2:0]       o_cycle_idx,
   output logic [ERR_W-1:0] o_err_count,
   output logic [BIN_W-1:0] o_max_jump,
   output logic [BIN_W-1:0] o_cyc_min,
   output logic [BIN_W-1:0] o_cyc_max,
   output logic             o_short_sweep,
   output logic             o_done,
   output logic             o_pass
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRST,
      S_TRACK,
      S_CYC_END,
      S_DONE
   } state_t;

   localparam logic [BIN_W-1:0] LAST_STEP = BIN_W'(NUM_TAPS - 1);
   localparam logic [BIN_W:0]   TOL_X     = (BIN_W + 1)'(TOL);
   localparam logic [3:0]       CYCLES_X  = 4'(CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t           r_state;
   logic [BIN_W-1:0] r_step_idx;
   logic [2:0]       r_cycle_idx;
   logic [ERR_W-1:0] r_err_count;
   logic [BIN_W-1:0] r_max_jump;
   logic [BIN_W-1:0] r_cyc_min;
   logic [BIN_W-1:0] r_cyc_max;
   logic [BIN_W-1:0] r_prev_bin;
   logic             r_short_sweep;
   logic             r_done;
   logic             r_pass;

   state_t           w_state_nxt;
   logic [BIN_W-1:0] w_step_nxt;
   logic [2:0]       w_cycle_nxt;
   logic [ERR_W-1:0] w_err_nxt;
   logic [BIN_W-1:0] w_max_jump_nxt;
   logic [BIN_W-1:0] w_cyc_min_nxt;
   logic [BIN_W-1:0] w_cyc_max_nxt;
   logic [BIN_W-1:0] w_prev_nxt;
   logic             w_short_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;
   logic             w_err_inc;
   logic [3:0]       w_cyc_would;

   logic [BIN_W:0]   w_bin_x;
   logic [BIN_W:0]   w_prev_x;
   logic             w_backstep;
   logic             w_forward;
   logic [BIN_W-1:0] w_jump;
   logic             w_sampling;

   // Widened by one bit so bin + TOL cannot wrap below prev_bin.
   assign w_bin_x    = {1'b0, i_bin_value};
   assign w_prev_x   = {1'b0, r_prev_bin};
   assign w_backstep = (w_bin_x + TOL_X) < w_prev_x;
   assign w_forward  = i_bin_value >= r_prev_bin;
   assign w_jump     = i_bin_value - r_prev_bin;
   assign w_sampling = (r_state == S_FIRST) || (r_state == S_TRACK) || (r_state == S_CYC_END);

   always_comb begin
      w_state_nxt    = r_state;
      w_step_nxt     = r_step_idx;
      w_cycle_nxt    = r_cycle_idx;
      w_err_nxt      = r_err_count;
      w_max_jump_nxt = r_max_jump;
      w_cyc_min_nxt  = r_cyc_min;
      w_cyc_max_nxt  = r_cyc_max;
      w_prev_nxt     = r_prev_bin;
      w_short_nxt    = r_short_sweep;
      w_done_nxt     = r_done;
      w_pass_nxt     = r_pass;
      w_err_inc      = 1'b0;
      w_cyc_would    = {1'b0, r_cycle_idx};

      if (!i_enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_step_nxt     = '0;
               w_cycle_nxt    = '0;
               w_err_nxt      = '0;
               w_max_jump_nxt = '0;
               w_cyc_min_nxt  = '1;
               w_cyc_max_nxt  = '0;
               w_prev_nxt     = '0;
               w_short_nxt    = 1'b0;
               w_done_nxt     = 1'b0;
               w_pass_nxt     = 1'b0;
               w_state_nxt    = S_FIRST;
            end
            S_FIRST: begin
               if (i_bin_valid) begin
                  w_prev_nxt    = i_bin_value;
                  w_cyc_min_nxt = i_bin_value;
                  w_cyc_max_nxt = i_bin_value;
                  w_step_nxt    = BIN_W'(1);
                  w_state_nxt   = S_TRACK;
               end
            end
            S_TRACK: begin
               if (i_bin_valid) begin
                  w_err_inc  = w_backstep;
                  w_prev_nxt = i_bin_value;
                  if (w_forward && (w_jump > r_max_jump)) begin
                     w_max_jump_nxt = w_jump;
                  end
                  if (i_bin_value < r_cyc_min) begin
                     w_cyc_min_nxt = i_bin_value;
                  end
                  if (i_bin_value > r_cyc_max) begin
                     w_cyc_max_nxt = i_bin_value;
                  end
                  if (r_step_idx == LAST_STEP) begin
                     w_cyc_would = {1'b0, r_cycle_idx} + 4'd1;
                     w_state_nxt = S_CYC_END;
                  end else begin
                     w_step_nxt = r_step_idx + BIN_W'(1);
                  end
               end
            end
            S_CYC_END: begin
               w_cycle_nxt = r_cycle_idx + 3'd1;
               w_cyc_would = {1'b0, r_cycle_idx} + 4'd1;
               w_err_inc   = i_bin_valid;
               if (w_cyc_would == CYCLES_X) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_step_nxt  = '0;
                  w_state_nxt = S_FIRST;
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase

         if (w_err_inc && (r_err_count != ERR_MAX)) begin
            w_err_nxt = r_err_count + ERR_W'(1);
         end

         // Any pending bin has already been folded into w_cyc_would, so an end-of-sweep
         // arriving with the final bin is judged against the completed cycle count.
         if (w_sampling && i_sweep_finished && (w_cyc_would < CYCLES_X)) begin
            w_short_nxt = 1'b1;
            w_state_nxt = S_DONE;
         end

         if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
            w_done_nxt = 1'b1;
            w_pass_nxt = (w_err_nxt == '0) && !w_short_nxt;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_step_idx    <= '0;
         r_cycle_idx   <= '0;
         r_err_count   <= '0;
         r_max_jump    <= '0;
         r_cyc_min     <= '1;
         r_cyc_max     <= '0;
         r_prev_bin    <= '0;
         r_short_sweep <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
      end else begin
         r_step_idx    <= w_step_nxt;
         r_cycle_idx   <= w_cycle_nxt;
         r_err_count   <= w_err_nxt;
         r_max_jump    <= w_max_jump_nxt;
         r_cyc_min     <= w_cyc_min_nxt;
         r_cyc_max     <= w_cyc_max_nxt;
         r_prev_bin    <= w_prev_nxt;
         r_short_sweep <= w_short_nxt;
         r_done        <= w_done_nxt;
         r_pass        <= w_pass_nxt;
      end
   end

   assign o_step_idx    = r_step_idx;
   assign o_cycle_idx   = r_cycle_idx;
   assign o_err_count   = r_err_count;
   assign o_max_jump    = r_max_jump;
   assign o_cyc_min     = r_cyc_min;
   assign o_cyc_max     = r_cyc_max;
   assign o_short_sweep = r_short_sweep;
   assign o_done        = r_done;
   assign o_pass        = r_pass;

endmodule

// File: tb/tb_tdc_sweep_checker.sv
// Directed bench for tdc_sweep_checker: vector table for the in-cycle monotonicity rules,
// hand-written sequences for full sweeps, short sweeps, reset and enable aborts.
module tb_tdc_sweep_checker;

   localparam int NUM_TAPS = 240;
   localparam int BIN_W    = 9;
   localparam int CYCLES   = 3;
   localparam int TOL      = 2;
   localparam int ERR_W    = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             bin_valid = 1'b0;
   logic [BIN_W-1:0] bin_value = '0;
   logic             sweep_finished = 1'b0;
   logic [BIN_W-1:0] step_idx;
   logic [2:0]       cycle_idx;
   logic [ERR_W-1:0] err_count;
   logic [BIN_W-1:0] max_jump;
   logic [BIN_W-1:0] cyc_min;
   logic [BIN_W-1:0] cyc_max;
   logic             short_sweep;
   logic             done;
   logic             pass;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic en;
      logic valid;
      int   value;
      logic sf;
      int   expStep;
      int   expErr;
      int   expJump;
      int   expMin;
      int   expMax;
   } vec_t;

   vec_t vecs[10];

   tdc_sweep_checker #(
      .NUM_TAPS(NUM_TAPS),
      .BIN_W(BIN_W),
      .CYCLES(CYCLES),
      .TOL(TOL),
      .ERR_W(ERR_W)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_enable(enable),
      .i_bin_valid(bin_valid),
      .i_bin_value(bin_value),
      .i_sweep_finished(sweep_finished),
      .o_step_idx(step_idx),
      .o_cycle_idx(cycle_idx),
      .o_err_count(err_count),
      .o_max_jump(max_jump),
      .o_cyc_min(cyc_min),
      .o_cyc_max(cyc_max),
      .o_short_sweep(short_sweep),
      .o_done(done),
      .o_pass(pass)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_step"}, int'(step_idx), 0);
      checkOutput({tag, "_cycle"}, int'(cycle_idx), 0);
      checkOutput({tag, "_err"}, int'(err_count), 0);
      checkOutput({tag, "_jump"}, int'(max_jump), 0);
      checkOutput({tag, "_min"}, int'(cyc_min), 511);
      checkOutput({tag, "_max"}, int'(cyc_max), 0);
      checkOutput({tag, "_short"}, int'(short_sweep), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
      checkOutput({tag, "_pass"}, int'(pass), 0);
   endtask

   task automatic checkFinal(input string tag, input int cyc, input int err, input int jump,
                             input int mn, input int mx, input int shrt, input int dn, input int ps);
      checkOutput({tag, "_cycle"}, int'(cycle_idx), cyc);
      checkOutput({tag, "_err"}, int'(err_count), err);
      checkOutput({tag, "_jump"}, int'(max_jump), jump);
      checkOutput({tag, "_min"}, int'(cyc_min), mn);
      checkOutput({tag, "_max"}, int'(cyc_max), mx);
      checkOutput({tag, "_short"}, int'(short_sweep), shrt);
      checkOutput({tag, "_done"}, int'(done), dn);
      checkOutput({tag, "_pass"}, int'(pass), ps);
   endtask

   // One vector per clock: drive on the falling edge, sample just after the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      enable         = v.en;
      bin_valid      = v.valid;
      bin_value      = BIN_W'(v.value);
      sweep_finished = v.sf;
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      bin_valid      = 1'b0;
      sweep_finished = 1'b0;
   endtask

   task automatic sendBin(input int value);
      @(negedge clk);
      bin_valid = 1'b1;
      bin_value = BIN_W'(value);
   endtask

   // Drives steps startStep..NUM_TAPS-1 back to back, then the CYC_END clock.
   task automatic runCycle(input int base, input int slope, input int startStep, input bit binAtEnd);
      for (int s = startStep; s < NUM_TAPS; s++) begin
         sendBin(base + slope * s);
      end
      @(negedge clk);
      bin_valid = binAtEnd;
      bin_value = BIN_W'(500);
   endtask

   task automatic restart();
      @(negedge clk);
      enable         = 1'b0;
      bin_valid      = 1'b0;
      sweep_finished = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0,   0, 1'b0, 0, 0, 0, 511,   0};
      vecs[1] = '{1'b1, 1'b1, 100, 1'b0, 1, 0, 0, 100, 100};
      vecs[2] = '{1'b1, 1'b1, 101, 1'b0, 2, 0, 1, 100, 101};
      vecs[3] = '{1'b1, 1'b1,  99, 1'b0, 3, 0, 1,  99, 101};
      vecs[4] = '{1'b1, 1'b0,   0, 1'b0, 3, 0, 1,  99, 101};
      vecs[5] = '{1'b1, 1'b1, 100, 1'b0, 4, 0, 1,  99, 101};
      vecs[6] = '{1'b1, 1'b1, 101, 1'b0, 5, 0, 1,  99, 101};
      vecs[7] = '{1'b1, 1'b1,  98, 1'b0, 6, 1, 1,  98, 101};
      vecs[8] = '{1'b1, 1'b1, 105, 1'b0, 7, 1, 7,  98, 105};
      vecs[9] = '{1'b1, 1'b1, 105, 1'b0, 8, 1, 7,  98, 105};

      repeat (2) @(negedge clk);
      checkReset("por");
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_step", i), int'(step_idx), vecs[i].expStep);
         checkOutput($sformatf("vec%0d_err", i), int'(err_count), vecs[i].expErr);
         checkOutput($sformatf("vec%0d_jump", i), int'(max_jump), vecs[i].expJump);
         checkOutput($sformatf("vec%0d_min", i), int'(cyc_min), vecs[i].expMin);
         checkOutput($sformatf("vec%0d_max", i), int'(cyc_max), vecs[i].expMax);
      end
      runCycle(97, 1, 8, 1'b0);
      runCycle(0, 2, 0, 1'b0);
      runCycle(0, 2, 0, 1'b0);
      settle();
      checkFinal("dip_end", 3, 1, 7, 0, 478, 0, 1, 0);

      // Ideal three-cycle sweep, entered by dropping and re-raising enable from DONE.
      restart();
      settle();
      checkReset("ideal_start");
      runCycle(0, 2, 0, 1'b0);
      settle();
      checkOutput("ideal_c1_cycle", int'(cycle_idx), 1);
      checkOutput("ideal_c1_step", int'(step_idx), 0);
      checkOutput("ideal_c1_max", int'(cyc_max), 478);
      checkOutput("ideal_c1_done", int'(done), 0);
      runCycle(0, 2, 0, 1'b0);
      runCycle(0, 2, 0, 1'b0);
      settle();
      checkFinal("ideal_end", 3, 0, 2, 0, 478, 0, 1, 1);
      checkOutput("ideal_end_step", int'(step_idx), NUM_TAPS - 1);
      sendBin(511);
      settle();
      checkFinal("done_ignore", 3, 0, 2, 0, 478, 0, 1, 1);

      // Bin during CYC_END is dropped as an error; then an early end-of-sweep.
      restart();
      runCycle(0, 2, 0, 1'b1);
      @(negedge clk);
      bin_valid      = 1'b0;
      sweep_finished = 1'b1;
      checkOutput("cycend_bin_err", int'(err_count), 1);
      checkOutput("cycend_bin_max", int'(cyc_max), 478);
      checkOutput("short_pre_cycle", int'(cycle_idx), 1);
      checkOutput("short_pre_done", int'(done), 0);
      settle();
      checkFinal("short_end", 1, 1, 2, 0, 478, 1, 1, 0);

      // Final bin and end-of-sweep land together on the last cycle.
      restart();
      runCycle(0, 2, 0, 1'b0);
      runCycle(0, 2, 0, 1'b0);
      for (int s = 0; s < NUM_TAPS - 1; s++) begin
         sendBin(2 * s);
      end
      @(negedge clk);
      bin_valid      = 1'b1;
      bin_value      = BIN_W'(478);
      sweep_finished = 1'b1;
      @(negedge clk);
      bin_valid = 1'b0;
      checkOutput("simul_cycend_cycle", int'(cycle_idx), 2);
      checkOutput("simul_cycend_done", int'(done), 0);
      checkOutput("simul_cycend_short", int'(short_sweep), 0);
      settle();
      checkFinal("simul_end", 3, 0, 2, 0, 478, 0, 1, 1);

      // Asynchronous reset in the middle of TRACK.
      restart();
      for (int s = 0; s < 57; s++) begin
         sendBin(2 * s);
      end
      settle();
      checkOutput("rst_pre_step", int'(step_idx), 57);
      checkOutput("rst_pre_max", int'(cyc_max), 112);
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      checkOutput("rst_restart_step", int'(step_idx), 0);
      sendBin(7);
      settle();
      checkOutput("rst_first_step", int'(step_idx), 1);
      checkOutput("rst_first_min", int'(cyc_min), 7);
      checkOutput("rst_first_max", int'(cyc_max), 7);
      checkOutput("rst_first_err", int'(err_count), 0);

      // Enable dropped at step 120 with an error already logged, then re-raised.
      restart();
      for (int s = 0; s < 120; s++) begin
         sendBin((s == 50) ? 0 : 2 * s);
      end
      settle();
      checkOutput("abort_pre_step", int'(step_idx), 120);
      checkOutput("abort_pre_err", int'(err_count), 1);
      checkOutput("abort_pre_jump", int'(max_jump), 102);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      checkOutput("abort_hold_step", int'(step_idx), 120);
      checkOutput("abort_hold_err", int'(err_count), 1);
      checkOutput("abort_hold_done", int'(done), 0);
      enable = 1'b1;
      settle();
      checkReset("abort_clear");
      sendBin(5);
      settle();
      checkOutput("abort_first_step", int'(step_idx), 1);
      checkOutput("abort_first_err", int'(err_count), 0);
      checkOutput("abort_first_min", int'(cyc_min), 5);
      checkOutput("abort_first_max", int'(cyc_max), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
